// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared AXI constants and bridge FSM encoding for the instruction/data SRAM-to-AXI bridges.
package inst_sram_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_e;

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// Instruction-side SRAM-like to single-beat AXI read bridge, one read outstanding at a time.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] ARID_VAL = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;

  // Write-side inputs and R-channel sideband are irrelevant with a single read in flight.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    case (state_q)
      IDLE: begin
        // Address is captured only here, so IF address wiggles during an AR stall never leak out.
        if (inst_sram_req) begin
          addr_d    = inst_sram_addr;
          size_d    = inst_sram_size;
          arvalid_d = 1'b1;
          state_d   = AR;
        end
      end
      AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = R;
        end
      end
      R: begin
        if (rvalid) begin
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arid    = ARID_VAL;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign inst_sram_addr_ok = arvalid_q & arready;
  assign inst_sram_data_ok = rvalid & rready_q;
  assign inst_sram_rdata   = rdata;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Scoreboard bench: IF-style master pushes expected reads, an AXI slave model answers, a monitor checks.
module tb_inst_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  inst_sram_axi_bridge #(.ARID_VAL(4'd0)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    int          issue;
    int          ar_lat;
    int          r_lat;
    int          ar_cyc;
  } exp_t;

  exp_t exp_ar_q[$];
  exp_t exp_r_q[$];

  int errors = 0;
  int checks = 0;

  // Slave knobs
  bit         rand_mode = 1'b0;
  int         ar_delay  = 0;
  int         r_delay   = 0;
  logic [1:0] rresp_val = 2'b00;

  // Instruction memory contents seen by the slave, indexed by byte address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'hbfc00000) return 32'h3c1d0001;
    if (a == 32'hbfc00100) return 32'hdeadbeef;
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // IF master: hold req until addr_ok, then drop it unless another request follows at once.
  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input int exp_ar_lat,
                         input int exp_r_lat, input bit change_addr, input bit hold);
    exp_t e;
    int   n;
    bit   ok;
    e.addr = a; e.size = sz; e.data = mem_f(a); e.issue = cyc;
    e.ar_lat = exp_ar_lat; e.r_lat = exp_r_lat; e.ar_cyc = 0;
    exp_ar_q.push_back(e);
    inst_sram_req  = 1'b1;
    inst_sram_addr = a;
    inst_sram_size = sz;
    n = 0; ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk); #3;
      ok = inst_sram_addr_ok;
      n++;
      if (change_addr && n == 2) inst_sram_addr = a + 32'd4;
    end
    if (!ok) chk("addr_ok_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) inst_sram_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_ar_q.size() != 0 || exp_r_q.size() != 0) && n < 500) begin
      @(negedge clk); #4;
      n++;
    end
    if (n >= 500) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // AXI slave model
  initial begin
    int          d;
    logic [31:0] cap;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rid = 4'd0; rlast = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (reset || !arvalid) continue;
      d = rand_mode ? int'($urandom_range(0, 3)) : ar_delay;
      for (int i = 0; i < d; i++) begin
        @(negedge clk); #1;
        if (reset) break;
      end
      if (reset) continue;
      arready = 1'b1;
      cap = araddr;
      @(negedge clk); #1;
      arready = 1'b0;
      if (reset) continue;
      d = rand_mode ? int'($urandom_range(0, 3)) : r_delay;
      for (int i = 0; i < d; i++) begin
        @(negedge clk); #1;
        if (reset) break;
      end
      if (reset) continue;
      rvalid = 1'b1;
      rdata  = mem_f(cap);
      rresp  = rand_mode ? 2'($urandom_range(0, 3)) : rresp_val;
      @(negedge clk); #1;
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'd0;
    end
  end

  // Monitor / scoreboard
  initial begin
    bit   rst_prev = 1'b0;
    int   n_out = 0;
    int   last_ar_cyc = -100;
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (reset) begin
        exp_ar_q.delete(); exp_r_q.delete();
        n_out = 0; last_ar_cyc = -100; rst_prev = 1'b1;
        continue;
      end
      if (rst_prev) begin
        chk("post_reset_arvalid", {31'd0, arvalid}, 32'd0);
        chk("post_reset_rready", {31'd0, rready}, 32'd0);
        chk("post_reset_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
        chk("post_reset_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
        chk("post_reset_araddr", araddr, 32'd0);
        rst_prev = 1'b0;
      end
      chk("addr_ok_eq", {31'd0, inst_sram_addr_ok}, {31'd0, arvalid & arready});
      chk("data_ok_eq", {31'd0, inst_sram_data_ok}, {31'd0, rvalid & rready});
      chk("arvalid_rready_excl", {31'd0, arvalid & rready}, 32'd0);
      if (exp_r_q.size() != 0) chk("rready_held", {31'd0, rready}, 32'd1);
      if (arvalid && arready) begin
        if (exp_ar_q.size() == 0) begin
          chk("unexpected_ar", 32'd1, 32'd0);
        end else begin
          e = exp_ar_q.pop_front();
          chk("araddr", araddr, e.addr);
          chk("arsize", {29'd0, arsize}, {30'd0, e.size});
          chk("ar_const", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
                          {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 9'd0});
          chk("outstanding", 32'(n_out), 32'd0);
          chk("ar_spacing_ge3", {31'd0, (cyc - last_ar_cyc) >= 3}, 32'd1);
          if (e.ar_lat >= 0) chk("ar_latency", 32'(cyc - e.issue), 32'(e.ar_lat));
          e.ar_cyc = cyc;
          last_ar_cyc = cyc;
          exp_r_q.push_back(e);
          n_out++;
        end
      end
      if (inst_sram_data_ok) begin
        if (exp_r_q.size() == 0 || exp_r_q[0].ar_cyc == cyc) begin
          chk("unexpected_data_ok", 32'd1, 32'd0);
        end else begin
          e = exp_r_q.pop_front();
          chk("rdata", inst_sram_rdata, e.data);
          if (e.r_lat >= 0) chk("r_latency", 32'(cyc - e.issue), 32'(e.r_lat));
          n_out--;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int g;
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 4'd0; inst_sram_addr = 32'd0; inst_sram_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // Zero-wait single read
    do_read(32'hbfc00000, 2'd2, 1, 2, 1'b0, 1'b0);
    wait_idle();

    // arready stall with IF address changing underneath
    ar_delay = 5;
    do_read(32'hbfc00000, 2'd2, 6, 7, 1'b1, 1'b0);
    wait_idle();
    ar_delay = 0;

    // rvalid delayed 7 cycles
    r_delay = 7;
    do_read(32'hbfc00004, 2'd2, 1, 9, 1'b0, 1'b0);
    wait_idle();
    r_delay = 0;

    // IF-style continuous fetch
    do_read(32'hbfc00000, 2'd2, 1, -1, 1'b0, 1'b1);
    do_read(32'hbfc00004, 2'd2, -1, -1, 1'b0, 1'b1);
    do_read(32'hbfc00008, 2'd2, -1, -1, 1'b0, 1'b0);
    wait_idle();

    // Reset while waiting in R, then a clean read
    r_delay = 50;
    do_read(32'hbfc00008, 2'd2, -1, -1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    r_delay = 0;
    @(posedge clk); #1;
    do_read(32'hbfc00000, 2'd2, 1, 2, 1'b0, 1'b0);
    wait_idle();

    // Error response still delivers data
    rresp_val = 2'b10;
    do_read(32'hbfc00100, 2'd2, 1, 2, 1'b0, 1'b0);
    wait_idle();
    rresp_val = 2'b00;

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      do_read({$urandom, 2'b00} , 2'($urandom_range(0, 2)), -1, -1, 1'b0, 1'($urandom_range(0, 1)));
      if (!inst_sram_req) begin
        g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
          @(posedge clk); #1;
        end
      end
    end
    inst_sram_req = 1'b0;
    wait_idle();
    chk("queues_drained", 32'(exp_ar_q.size() + exp_r_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
